// File: rtl/gate_recv_if.sv
// gate_recv_if: AXI-stream bundle; tuser carries the route tag inbound and the destination index outbound.
interface gate_recv_if #(
  parameter int DATA_BITS = 512,
  parameter int USER_BITS = 14
);
  logic                   tvalid;
  logic                   tready;
  logic [DATA_BITS-1:0]   tdata;
  logic [DATA_BITS/8-1:0] tkeep;
  logic                   tlast;
  logic [USER_BITS-1:0]   tuser;
  modport master(output tvalid, tdata, tkeep, tlast, tuser, input tready);
  modport slave(input tvalid, tdata, tkeep, tlast, tuser, output tready);
endinterface

// File: rtl/gate_recv.sv
// gate_recv: receive-side route-capability gate; forwards packets whose tag matches the cap table, drops the rest.
// Define GATE_RECV_DROP_CNT_EN to enable the saturating drop counter (otherwise drop_cnt is tied to 0).
module gate_recv #(
  parameter int N_DESTS   = 4,
  parameter int DATA_BITS = 512,
  parameter int CNT_BITS  = 32
) (
  input  logic                aclk,
  input  logic                areset,
  input  logic                cap_wr_valid,
  input  logic [13:0]         cap_wr_data,
  gate_recv_if.slave          s,
  gate_recv_if.master         m,
  output logic                drop_pulse,
  output logic [CNT_BITS-1:0] drop_cnt
);
  typedef enum logic [1:0] {IDLE, CHECK, PASS, DROP} state_t;
  state_t      state, state_nx;
  logic [13:0] route_q;
  logic [13:0] entry [4];
  logic [3:0]  valid;
  logic        match, accept, wr_ok;
  assign wr_ok  = cap_wr_valid && ({1'b0, cap_wr_data[1:0]} < 3'(N_DESTS));
  assign match  = valid[route_q[1:0]] && ({1'b0, route_q[1:0]} < 3'(N_DESTS)) &&
                  entry[route_q[1:0]] == route_q;
  assign s.tready = state == PASS ? (!m.tvalid || m.tready) : state == DROP;
  assign accept   = s.tvalid && s.tready;
  always_ff @(posedge aclk or posedge areset)
    if (areset) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    state_nx = s.tvalid ? CHECK : IDLE;
      CHECK:   state_nx = match ? PASS : DROP;
      default: state_nx = accept && s.tlast ? IDLE : state;
    endcase
  end
  // The table write and the CHECK lookup share an edge, so the lookup sees pre-write contents.
  always_ff @(posedge aclk or posedge areset)
    if (areset) begin
      route_q    <= '0;
      valid      <= '0;
      drop_pulse <= 1'b0;
      m.tvalid   <= 1'b0;
      m.tdata    <= '0;
      m.tkeep    <= '0;
      m.tlast    <= 1'b0;
      m.tuser    <= '0;
      for (int i = 0; i < 4; i++) entry[i] <= '0;
    end else begin
      if (state == IDLE && s.tvalid) route_q <= s.tuser;
      drop_pulse <= state == CHECK && !match;
      if (wr_ok) begin
        entry[cap_wr_data[1:0]] <= cap_wr_data;
        valid[cap_wr_data[1:0]] <= 1'b1;
      end
      if (state == PASS && accept) begin
        m.tvalid <= 1'b1;
        m.tdata  <= s.tdata;
        m.tkeep  <= s.tkeep;
        m.tlast  <= s.tlast;
        m.tuser  <= route_q[1:0];
      end else if (m.tready) m.tvalid <= 1'b0;
    end
`ifdef GATE_RECV_DROP_CNT_EN
  always_ff @(posedge aclk or posedge areset)
    if (areset) drop_cnt <= '0;
    else if (state == CHECK && !match && drop_cnt != '1) drop_cnt <= drop_cnt + 1'b1;
`else
  assign drop_cnt = '0;
`endif
endmodule

// File: tb/tb_gate_recv.sv
// tb_gate_recv: directed stimulus with a queue scoreboard and an independent output monitor.
module tb_gate_recv;
  logic        aclk = 1'b0;
  logic        areset = 1'b1;
  logic        cap_wr_valid = 1'b0;
  logic [13:0] cap_wr_data = '0;
  logic        drop_pulse;
  logic [31:0] drop_cnt;
  gate_recv_if #(.DATA_BITS(512), .USER_BITS(14)) s_if ();
  gate_recv_if #(.DATA_BITS(512), .USER_BITS(2))  m_if ();
  gate_recv dut (
    .aclk(aclk), .areset(areset), .cap_wr_valid(cap_wr_valid), .cap_wr_data(cap_wr_data),
    .s(s_if), .m(m_if), .drop_pulse(drop_pulse), .drop_cnt(drop_cnt)
  );
  always #5 aclk = ~aclk;
  typedef struct packed {logic [511:0] d; logic [63:0] k; logic l; logic [1:0] dest;} beat_t;
  beat_t exp_q[$];
  int n_cmp = 0, n_err = 0;
  int exp_drops = 0, exp_pulses = 0, seen_pulses = 0;
  logic toggle = 1'b0;
  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  function automatic logic [511:0] mk_data(input int b);
    logic [31:0] w;
    w = b;
    return {16{w}};
  endfunction
  task automatic drive_beat(input logic [511:0] d, input logic [63:0] k, input logic l, input logic [13:0] r);
    bit ok;
    int t;
    ok = 0;
    t = 0;
    s_if.tvalid = 1'b1;
    s_if.tdata  = d;
    s_if.tkeep  = k;
    s_if.tlast  = l;
    s_if.tuser  = r;
    while (!ok) begin
      @(negedge aclk);
      ok = s_if.tready;
      @(posedge aclk);
      #1;
      t++;
      if (!ok && t > 50) begin
        n_cmp++;
        n_err++;
        $display("FAIL accept_timeout: beat not accepted within %0d cycles", t);
        ok = 1;
      end
    end
    s_if.tvalid = 1'b0;
    s_if.tlast  = 1'b0;
  endtask
  task automatic send_pkt(input logic [13:0] r, input int n, input int base, input bit pass);
    logic [511:0] d;
    logic [63:0]  k;
    for (int i = 0; i < n; i++) begin
      d = mk_data(base + i);
      k = (i == n - 1) ? 64'h0000_0000_FFFF_FFFF : '1;
      if (pass) exp_q.push_back('{d: d, k: k, l: i == n - 1, dest: r[1:0]});
      drive_beat(d, k, i == n - 1, r);
    end
    if (!pass) begin
      exp_drops++;
      exp_pulses++;
    end
  endtask
  task automatic cap_write(input logic [13:0] c);
    cap_wr_valid = 1'b1;
    cap_wr_data  = c;
    @(posedge aclk);
    #1;
    cap_wr_valid = 1'b0;
  endtask
  task automatic drain_and_check(input string tag);
    for (int i = 0; i < 60 && (exp_q.size() != 0 || m_if.tvalid); i++) @(posedge aclk);
    repeat (3) @(posedge aclk);
    #1;
    chk({tag, "_drain"}, exp_q.size(), 0);
`ifdef GATE_RECV_DROP_CNT_EN
    chk({tag, "_drop_cnt"}, drop_cnt, exp_drops);
`else
    chk({tag, "_drop_cnt"}, drop_cnt, 0);
`endif
    chk({tag, "_drop_pulses"}, seen_pulses, exp_pulses);
  endtask
  initial forever begin
    @(posedge aclk);
    #1;
    m_if.tready = toggle ? ~m_if.tready : 1'b1;
  end
  initial begin
    logic         pv, pr;
    logic [511:0] pd;
    logic [66:0]  pm;
    beat_t        e;
    pv = 0;
    pr = 0;
    pd = '0;
    pm = '0;
    forever begin
      @(negedge aclk);
      if (drop_pulse) seen_pulses++;
      if (pv && !pr && !areset) begin
        chk("stall_data", m_if.tdata, pd);
        chk("stall_meta", {m_if.tkeep, m_if.tlast, m_if.tuser}, pm);
      end
      if (m_if.tvalid && m_if.tready) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_beat: got data %0h with nothing expected", m_if.tdata);
        end else begin
          e = exp_q.pop_front();
          chk("beat_data", m_if.tdata, e.d);
          chk("beat_keep_last_dest", {m_if.tkeep, m_if.tlast, m_if.tuser}, {e.k, e.l, e.dest});
        end
      end
      pv = m_if.tvalid;
      pr = m_if.tready;
      pd = m_if.tdata;
      pm = {m_if.tkeep, m_if.tlast, m_if.tuser};
    end
  end
  initial begin
    int n;
    s_if.tvalid = 1'b0;
    s_if.tdata  = '0;
    s_if.tkeep  = '0;
    s_if.tlast  = 1'b0;
    s_if.tuser  = '0;
    m_if.tready = 1'b1;
    repeat (3) @(posedge aclk);
    #1;
    chk("rst_s_tready", s_if.tready, 0);
    chk("rst_m_tvalid", m_if.tvalid, 0);
    chk("rst_m_tdata", m_if.tdata, 0);
    chk("rst_m_meta", {m_if.tkeep, m_if.tlast, m_if.tuser}, 0);
    chk("rst_drop", {drop_pulse, drop_cnt}, 0);
    areset = 1'b0;
    @(posedge aclk);
    #1;
    // basic pass with latency check
    cap_write(14'h1A5);
    fork
      send_pkt(14'h1A5, 4, 'h100, 1);
      begin
        n = 0;
        while (n < 10) begin
          @(negedge aclk);
          if (m_if.tvalid) break;
          @(posedge aclk);
          n++;
        end
        chk("first_beat_latency", n, 3);
      end
    join
    drain_and_check("pass4");
    send_pkt(14'h1A6, 3, 'h200, 0);
    drain_and_check("drop_unwritten");
    // overwrite idx1 during CHECK: this packet still passes, the next one with the old tag drops
    fork
      send_pkt(14'h1A5, 2, 'h300, 1);
      begin
        @(posedge aclk);
        #2;
        cap_wr_valid = 1'b1;
        cap_wr_data  = 14'h2F5;
        @(posedge aclk);
        #1;
        cap_wr_valid = 1'b0;
      end
    join
    send_pkt(14'h1A5, 1, 'h310, 0);
    send_pkt(14'h2F5, 1, 'h320, 1);
    drain_and_check("overwrite");
    toggle = 1'b1;
    send_pkt(14'h2F5, 5, 'h400, 1);
    send_pkt(14'h2F5, 2, 'h410, 1);
    drain_and_check("toggle");
    toggle = 1'b0;
    @(posedge aclk);
    #1;
    // reset on beat 2 of a passing packet
    exp_q.push_back('{d: mk_data('h500), k: '1, l: 1'b0, dest: 2'd1});
    drive_beat(mk_data('h500), '1, 1'b0, 14'h2F5);
    s_if.tvalid = 1'b1;
    s_if.tdata  = mk_data('h501);
    @(negedge aclk);
    #1;
    areset = 1'b1;
    #1;
    chk("arst_m_tvalid", m_if.tvalid, 0);
    chk("arst_m_tdata", m_if.tdata, 0);
    chk("arst_m_meta", {m_if.tkeep, m_if.tlast, m_if.tuser}, 0);
    chk("arst_s_tready", s_if.tready, 0);
    chk("arst_drop_cnt", drop_cnt, 0);
    exp_drops = 0;
    @(posedge aclk);
    #1;
    areset = 1'b0;
    send_pkt(14'h2F5, 3, 'h501, 0);
    drain_and_check("after_reset");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
